// File: rtl/sm_imem_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sm_imem_loader_pkg                                              |
// | Purpose  : Shared types and constants for the instruction-memory loader:   |
// |            FSM state encoding, LEN field width and bytes per word.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package sm_imem_loader_pkg;

  localparam int LEN_WIDTH      = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_WIDTH = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_LEN0 = 3'd0,
    ST_LEN1 = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  // The loader takes host bytes only in the frame-receiving states.
  function automatic logic state_is_busy(input state_t s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sm_imem_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sm_imem_loader_if                                               |
// | Purpose  : Host byte link (valid/ready) plus instruction-RAM write port.   |
// |            slave = loader side, master = host/RAM side.                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface sm_imem_loader_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/sm_imem_loader_byte_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sm_imem_loader_byte_packer                                      |
// | Purpose  : Assembles little-endian words from a byte stream. Byte k lands  |
// |            in word[8k+7:8k]; word_valid pulses the cycle after the last    |
// |            byte of a word. clear drops any partial word.                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sm_imem_loader_byte_packer
  import sm_imem_loader_pkg::*;
(
  input  wire logic                        clk,
  input  wire logic                        clear,
  input  wire logic                        byte_valid,
  input  wire logic [7:0]                  byte_in,
  output logic                             last_byte,
  output logic                             word_valid,
  output logic [8*BYTES_PER_WORD-1:0]      word
);

  logic [BYTE_CNT_WIDTH-1:0] cnt;

  assign last_byte = (cnt == BYTE_CNT_WIDTH'(BYTES_PER_WORD - 1));

  // Byte lane selection by counter; a full word raises word_valid for one cycle.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_valid & last_byte;
      if (byte_valid) begin
        word[{cnt, 3'b000} +: 8] <= byte_in;
        cnt                      <= cnt + BYTE_CNT_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sm_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sm_imem_loader                                                  |
// | Purpose  : Receives a LEN-prefixed byte image, writes it as 32-bit words   |
// |            into instruction RAM and holds the core in reset until done.    |
// |            Optional trailing XOR checksum: SM_LOADER_CHECKSUM_EN.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sm_imem_loader
  import sm_imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         load_req,
  sm_imem_loader_if.slave   bus,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              err
);

  localparam logic [LEN_WIDTH:0] CAPACITY = (LEN_WIDTH+1)'(1) << ADDR_WIDTH;

  state_t                 state, state_nx;
  logic [7:0]             len_lo;
  logic [LEN_WIDTH-1:0]   len;
  logic [LEN_WIDTH-1:0]   len_rx;
  logic [ADDR_WIDTH-1:0]  word_idx;
  logic                   accept;
  logic                   data_accept;
  logic                   last_byte;
  logic                   last_word;
  logic                   clear;

  assign busy          = state_is_busy(state);
  assign err           = (state == ST_ERR);
  assign bus.in_ready  = busy;
  assign accept        = bus.in_valid & bus.in_ready;
  // A load_req in the same cycle discards the byte, so it never reaches the packer.
  assign data_accept   = accept & (state == ST_DATA) & ~load_req;
  assign clear         = rst | load_req;
  assign len_rx        = {bus.in_data, len_lo};
  assign last_word     = (LEN_WIDTH'(word_idx) == (len - LEN_WIDTH'(1)));

  sm_imem_loader_byte_packer u_packer (
    .clk        (clk),
    .clear      (clear),
    .byte_valid (data_accept),
    .byte_in    (bus.in_data),
    .last_byte  (last_byte),
    .word_valid (bus.wr_en),
    .word       (bus.wr_data)
  );

`ifdef SM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR over data bytes only; LEN is excluded.
  always_ff @(posedge clk) begin
    if (clear) begin
      csum <= '0;
    end else if (data_accept) begin
      csum <= csum ^ bus.in_data;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_LEN0;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; load_req restarts from any state.
  always_comb begin
    state_nx = state;
    if (load_req) begin
      state_nx = ST_LEN0;
    end else begin
      case (state)
        ST_LEN0: if (accept) state_nx = ST_LEN1;
        ST_LEN1: begin
          if (accept) begin
            if (len_rx == '0) begin
`ifdef SM_LOADER_CHECKSUM_EN
              state_nx = ST_CSUM;
`else
              state_nx = ST_DONE;
`endif
            end else if ({1'b0, len_rx} > CAPACITY) begin
              state_nx = ST_ERR;
            end else begin
              state_nx = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (accept && last_byte && last_word) begin
`ifdef SM_LOADER_CHECKSUM_EN
            state_nx = ST_CSUM;
`else
            state_nx = ST_DONE;
`endif
          end
        end
`ifdef SM_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (accept) state_nx = (bus.in_data == csum) ? ST_DONE : ST_ERR;
        end
`endif
        default: state_nx = state;
      endcase
    end
  end

  // Length capture, word bookkeeping, write address and core-reset release.
  always_ff @(posedge clk) begin
    if (clear) begin
      len_lo      <= '0;
      len         <= '0;
      word_idx    <= '0;
      bus.wr_addr <= '0;
      cpu_rst_n   <= 1'b0;
    end else begin
      // Registered from state so the final write (first DONE cycle) precedes release.
      cpu_rst_n <= (state == ST_DONE);
      if (accept && state == ST_LEN0) len_lo <= bus.in_data;
      if (accept && state == ST_LEN1) len    <= len_rx;
      if (data_accept && last_byte)   word_idx <= word_idx + ADDR_WIDTH'(1);
      // Saturate at the top word rather than wrapping back to 0.
      if (bus.wr_en && bus.wr_addr != {ADDR_WIDTH{1'b1}}) begin
        bus.wr_addr <= bus.wr_addr + ADDR_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire
